// File: rtl/rv_ctrl_pkg.sv
// Shared opcodes, ALU control codes and FSM state encoding for the multi-cycle
// RV32 control unit.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  function automatic logic op_legal(input logic [6:0] op, input logic i_alu_en);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_R) ||
           (i_alu_en && (op == OP_I));
  endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational ALU control decode from opcode, funct3 and instr[30].
// Keeps the legacy aluctrl encoding (and/or/add/sub).
module rv_alu_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alt,
  output logic [3:0] aluctrl
);
  import rv_ctrl_pkg::*;

  always_comb begin
    aluctrl = ALU_ADD;
    case (opcode)
      OP_BEQ: aluctrl = ALU_SUB;
      OP_R: begin
        case ({alt, funct3})
          4'b1000: aluctrl = ALU_SUB;
          4'b0111: aluctrl = ALU_AND;
          4'b0110: aluctrl = ALU_OR;
          default: aluctrl = ALU_ADD;
        endcase
      end
      // There is no subi, so instr[30] plays no part for immediates.
      OP_I: begin
        case (funct3)
          3'b111:  aluctrl = ALU_AND;
          3'b110:  aluctrl = ALU_OR;
          default: aluctrl = ALU_ADD;
        endcase
      end
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with IR and bus wait timer.
// Optional illegal-opcode trap enabled by defining MC_CTRL_TRAP_EN.
module mc_control #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5,
  parameter int I_ALU_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        alusrc,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        branch,
  output logic [3:0]  aluctrl,
  output logic        bus_err,
  output logic        illegal
);
  import rv_ctrl_pkg::*;

  state_t            state, state_next;
  logic [6:0]        ir_op;
  logic [2:0]        ir_f3;
  logic              ir_alt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              bus_err_q;
  logic [3:0]        dec_alu;
  logic              is_lw, is_sw, is_beq, is_i, legal;
  logic              pending, timeout;
  logic              unused;

  // Only the control fields of the instruction are held here.
  assign unused = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_lw  = (ir_op == OP_LW);
  assign is_sw  = (ir_op == OP_SW);
  assign is_beq = (ir_op == OP_BEQ);
  assign is_i   = (I_ALU_EN != 0) && (ir_op == OP_I);
  assign legal  = op_legal(ir_op, I_ALU_EN != 0);

  rv_alu_decode u_alu_decode (
    .opcode  (ir_op),
    .funct3  (ir_f3),
    .alt     (ir_alt),
    .aluctrl (dec_alu)
  );

  // Handshake: a request rises on entry to FETCH/MEM and holds steady until
  // the cycle its ready is high; that cycle is the transfer. Ready is ignored
  // whenever the matching request is low.
  assign pending = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
  assign timeout = (WAIT_MAX != 0) && pending && (wait_cnt == WAIT_W'(WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      ir_op     <= '0;
      ir_f3     <= '0;
      ir_alt    <= 1'b0;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == FETCH) && imem_ready) begin
        ir_op  <= instr[6:0];
        ir_f3  <= instr[14:12];
        ir_alt <= instr[30];
      end
      if (pending && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

`ifdef MC_CTRL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          illegal_q <= 1'b0;
    else if ((state == DECODE) && !legal) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign bus_err = bus_err_q;

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alusrc     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    branch     = 1'b0;
    aluctrl    = 4'b0000;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = HALT;
        end
      end
      DECODE: begin
        if (legal) state_next = EXEC;
`ifdef MC_CTRL_TRAP_EN
        else       state_next = HALT;
`else
        else       state_next = FETCH;
`endif
      end
      EXEC: begin
        aluctrl = dec_alu;
        if (is_lw || is_sw) begin
          alusrc     = 1'b1;
          aluctrl    = ALU_ADD;
          state_next = MEM;
        end else if (is_beq) begin
          branch     = 1'b1;
          pc_write   = zero;
          state_next = FETCH;
        end else begin
          alusrc     = is_i;
          state_next = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        memread  = is_lw;
        memwrite = is_sw;
        if (dmem_ready)   state_next = is_lw ? WB : FETCH;
        else if (timeout) state_next = HALT;
      end
      WB: begin
        regwrite   = 1'b1;
        memtoreg   = is_lw;
        alusrc     = is_i;
        aluctrl    = is_lw ? 4'b0000 : dec_alu;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
    // Strobes vanish the moment reset asserts, aborting any in-flight access.
    if (!rst_n) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      branch   = 1'b0;
      aluctrl  = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected output traces built
// from instruction-level timing rules, with randomized wait states and inputs.
`timescale 1ns/1ps
module tb_mc_control;

  localparam int WAIT_MAX = 16;

  localparam logic [6:0] T_LW = 7'h03, T_SW = 7'h23, T_BEQ = 7'h63, T_R = 7'h33, T_I = 7'h13;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110;

  localparam logic [15:0] M_IREQ = 16'h8000, M_DREQ = 16'h4000, M_IRW = 16'h2000;
  localparam logic [15:0] M_PCW  = 16'h1000, M_ASRC = 16'h0800, M_M2R = 16'h0400;
  localparam logic [15:0] M_RW   = 16'h0200, M_MR   = 16'h0100, M_MW  = 16'h0080;
  localparam logic [15:0] M_BR   = 16'h0040, M_BE   = 16'h0002, M_IL  = 16'h0001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, zero = 1'b0;
  logic imem_req, dmem_req, ir_write, pc_write, alusrc, memtoreg, regwrite;
  logic memread, memwrite, branch, bus_err, illegal;
  logic [3:0] aluctrl;
  logic [15:0] obs;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] ins;
    logic        ir;
    logic        dr;
    logic        z;
  } stim_t;

  stim_t       stim_q[$];
  logic [15:0] exp_q[$];

  mc_control #(.WAIT_MAX(WAIT_MAX), .WAIT_W(5), .I_ALU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .imem_req(imem_req), .dmem_req(dmem_req),
    .ir_write(ir_write), .pc_write(pc_write), .alusrc(alusrc), .memtoreg(memtoreg),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .branch(branch),
    .aluctrl(aluctrl), .bus_err(bus_err), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  assign obs = {imem_req, dmem_req, ir_write, pc_write, alusrc, memtoreg, regwrite,
                memread, memwrite, branch, aluctrl, bus_err, illegal};

  // ---------------- reference model ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] af(input logic [3:0] a);
    return {10'b0, a, 2'b0};
  endfunction

  function automatic logic [3:0] alu_ref(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (ins[6:0] == T_BEQ) return A_SUB;
    if (ins[6:0] == T_R) begin
      if (ins[30] && f3 == 3'd0)  return A_SUB;
      if (!ins[30] && f3 == 3'd7) return A_AND;
      if (!ins[30] && f3 == 3'd6) return A_OR;
      return A_ADD;
    end
    if (ins[6:0] == T_I) begin
      if (f3 == 3'd7) return A_AND;
      if (f3 == 3'd6) return A_OR;
    end
    return A_ADD;
  endfunction

  task automatic push(input logic [31:0] ins, input logic i, input logic d,
                      input logic z, input logic [15:0] e);
    stim_t s;
    s.ins = ins; s.ir = i; s.dr = d; s.z = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_fetch(input logic [31:0] ins, input int iw);
    for (int i = 0; i < iw; i++) push($urandom, 1'b0, rb(), rb(), M_IREQ);
    push(ins, 1'b1, rb(), rb(), M_IREQ | M_IRW);
    push($urandom, rb(), rb(), rb(), 16'h0);  // decode
  endtask

  task automatic add_mem(input int dw, input logic [15:0] m);
    for (int i = 0; i < dw; i++) push($urandom, rb(), 1'b0, rb(), m);
    push($urandom, rb(), 1'b1, rb(), m);
  endtask

  // Full instruction trace: iw/dw are stall cycles before each ack.
  task automatic add_instr(input logic [31:0] ins, input int iw, input int dw, input logic z);
    logic [3:0] a;
    a = alu_ref(ins);
    add_fetch(ins, iw);
    case (ins[6:0])
      T_LW: begin
        push($urandom, rb(), rb(), rb(), M_ASRC | af(A_ADD));
        add_mem(dw, M_DREQ | M_MR);
        push($urandom, rb(), rb(), rb(), M_RW | M_M2R);
      end
      T_SW: begin
        push($urandom, rb(), rb(), rb(), M_ASRC | af(A_ADD));
        add_mem(dw, M_DREQ | M_MW);
      end
      T_BEQ: push($urandom, rb(), rb(), z, M_BR | af(A_SUB) | (z ? M_PCW : 16'h0));
      T_R: begin
        push($urandom, rb(), rb(), rb(), af(a));
        push($urandom, rb(), rb(), rb(), M_RW | af(a));
      end
      T_I: begin
        push($urandom, rb(), rb(), rb(), M_ASRC | af(a));
        push($urandom, rb(), rb(), rb(), M_RW | M_ASRC | af(a));
      end
      default: ;  // illegal opcode without trap: straight back to fetch
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic drive_next(output logic [15:0] got, output logic [15:0] e);
    stim_t s;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    instr = s.ins; imem_ready = s.ir; dmem_ready = s.dr; zero = s.z;
    #1;
    got = obs;
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0; imem_ready = rb(); dmem_ready = rb();
    #1;
    checks++;
    if (obs !== 16'h0) $display("FAIL %s: outputs %h during reset, expected 0000", name, obs);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      imem_ready = rb(); dmem_ready = rb(); zero = rb(); instr = $urandom;
      #1;
      checks++;
      if (obs !== 16'h0) $display("FAIL reset cycle %0d: got %h expected 0000", i, obs);
      else passed++;
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [15:0] got, e;
    add_instr(32'h0080af03, 0, 0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL lw cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_sw();
    logic [15:0] got, e;
    add_instr(32'hfe20aa23, 0, 3, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL sw_wait3 cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_beq();
    logic [15:0] got, e;
    add_instr(32'hfeb289e3, 0, 0, 1'b1);
    add_instr(32'hfeb289e3, 1, 0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL beq cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] got, e;
    add_instr(32'h40208f33, 0, 0, 1'b0);
    add_instr(32'h0020ef33, 2, 0, 1'b0);
    add_instr(32'h00508093, 0, 0, 1'b0);
    add_instr(32'h0070f093, 1, 0, 1'b0);
    add_instr(32'h0020ff33, 0, 0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL alu_ops cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_wait_boundary();
    logic [15:0] got, e;
    add_instr(32'h0080af03, WAIT_MAX, WAIT_MAX, 1'b0);
    add_instr(32'hfe20aa23, WAIT_MAX - 1, WAIT_MAX, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL wait_boundary cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [15:0] got, e;
`ifdef MC_CTRL_TRAP_EN
    add_fetch(32'h0000007f, 0);
    for (int i = 0; i < 4; i++) push($urandom, rb(), rb(), rb(), M_IL);
`else
    add_instr(32'h0000007f, 0, 0, 1'b0);
    add_instr(32'hfeb289e3, 0, 0, 1'b1);
`endif
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL illegal cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
`ifdef MC_CTRL_TRAP_EN
    do_reset("illegal_reset");
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, e;
    logic [31:0] ins;
    logic [6:0]  op;
    int          cls, iw, dw;
    for (int t = 0; t < 30; t++) begin
      ins = $urandom;
`ifdef MC_CTRL_TRAP_EN
      cls = $urandom_range(0, 4);
`else
      cls = $urandom_range(0, 5);
`endif
      case (cls)
        0: op = T_LW;
        1: op = T_SW;
        2: op = T_BEQ;
        3: op = T_R;
        4: op = T_I;
        default: begin
          op = 7'($urandom_range(0, 127));
          while (op == T_LW || op == T_SW || op == T_BEQ || op == T_R || op == T_I)
            op = 7'($urandom_range(0, 127));
        end
      endcase
      ins[6:0] = op;
      iw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_MAX) : 0;
      dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_MAX) : 0;
      add_instr(ins, iw, dw, rb());
    end
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL back_to_back cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_bus_err_fetch();
    logic [15:0] got, e;
    for (int i = 0; i <= WAIT_MAX; i++) push($urandom, 1'b0, rb(), rb(), M_IREQ);
    for (int i = 0; i < 4; i++) push($urandom, rb(), rb(), rb(), M_BE);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL bus_err_fetch cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
    do_reset("bus_err_fetch_reset");
    add_instr(32'h00508093, 0, 0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL after_bus_err cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  task automatic test_bus_err_mem();
    logic [15:0] got, e;
    add_fetch(32'hfe20aa23, 0);
    push($urandom, rb(), rb(), rb(), M_ASRC | af(A_ADD));
    for (int i = 0; i <= WAIT_MAX; i++) push($urandom, rb(), 1'b0, rb(), M_DREQ | M_MW);
    for (int i = 0; i < 3; i++) push($urandom, rb(), rb(), rb(), M_BE);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL bus_err_mem cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
    do_reset("bus_err_mem_reset");
  endtask

  task automatic test_reset_mid_mem();
    logic [15:0] got, e;
    add_fetch(32'hfe20aa23, 0);
    push($urandom, rb(), rb(), rb(), M_ASRC | af(A_ADD));
    for (int i = 0; i < 2; i++) push($urandom, rb(), 1'b0, rb(), M_DREQ | M_MW);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL mid_mem_setup cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== (M_DREQ | M_MW)) $display("FAIL mid_mem_before: got %h expected %h", obs, M_DREQ | M_MW);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 16'h0) $display("FAIL mid_mem_abort: got %h expected 0000", obs);
    else passed++;
    @(negedge clk);
    dmem_ready = 1'b1; imem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0) $display("FAIL mid_mem_held: got %h expected 0000", obs);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    add_instr(32'h0080af03, 1, 0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      drive_next(got, e);
      checks++;
      if (got !== e) $display("FAIL mid_mem_restart cycle %0d: got %h expected %h", n + 1, got, e);
      else passed++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_alu_ops();
    test_wait_boundary();
    test_illegal();
    test_back_to_back();
    test_bus_err_fetch();
    test_bus_err_mem();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
